squarer_rr_scheduler: RTL

- Shares one multi-cycle shift-add squaring engine among N_REQ requesters using round-robin arbitration.
- Each requester presents an operand with a req/gnt handshake. The block grants one requester, computes operand^2 over WIDTH cycles, then posts the result tagged with the requester id.
- Sits between the request-side clients and any consumer of square values. It is the sequenced, shared replacement for per-client combinational squarers.

---
 rtl/squarer_rr_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/squarer_rr_scheduler.sv
// Round-robin front end sharing one shift-add squaring engine among N_REQ clients.
// A granted operand is squared over WIDTH cycles and returned tagged with its owner id.
//
// state | meaning
// IDLE  | waiting for any req; picks the winner from ptr upward
// CALC  | one partial product per edge, bit k = 0..WIDTH-1
// DONE  | result_valid pulse cycle, req ignored
module squarer_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   operand,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     result_valid,
    output logic [ID_W-1:0]          result_id,
    output logic [2*WIDTH-1:0]       result
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   result_id_q;
    logic [WIDTH-1:0]  op_q;
    logic [RW-1:0]     acc_q;
    logic [RW-1:0]     result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_REQ-1:0]  gnt_q;
    logic              result_valid_q;

    logic              found_d;
    logic [ID_W-1:0]   winner_d;
    logic [ID_W-1:0]   ptr_d;
    logic [RW-1:0]     acc_d;
    logic [WIDTH-1:0]  op_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_op_split
        assign op_arr[g] = operand[g*WIDTH +: WIDTH];
    end

    // Rotating priority search starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx      = 0;
        found_d  = 1'b0;
        winner_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found_d && req[ID_W'(idx)]) begin
                found_d  = 1'b1;
                winner_d = ID_W'(idx);
            end
        end
        ptr_d = ID_W'((int'(winner_d) + 1) % N_REQ);
    end

    always_comb begin
        acc_d = acc_q;
        if (op_q[cnt_q]) begin
            acc_d = acc_q + (RW'(op_q) << cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            id_q           <= '0;
            result_id_q    <= '0;
            op_q           <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            cnt_q          <= '0;
            gnt_q          <= '0;
            result_valid_q <= 1'b0;
        end else begin
            gnt_q          <= '0;
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        op_q    <= op_arr[winner_d];
                        id_q    <= winner_d;
                        gnt_q   <= N_REQ'(1) << winner_d;
                        ptr_q   <= ptr_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q       <= acc_d;
                        result_valid_q <= 1'b1;
                        result_id_q    <= id_q;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign busy         = (state_q != IDLE);
    assign result_valid = result_valid_q;
    assign result_id    = result_id_q;
    assign result       = result_q;

endmodule
